// File: rtl/alu_share_ctrl.sv
// Two-client round-robin sequencer for an external combinational ALU.
// Each operation is one IDLE handshake, one EXEC cycle and a RESP hold until accepted.
module alu_share_ctrl #(
    parameter int W   = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_b0,
    input  logic [OPW-1:0] req_op0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b1,
    input  logic [OPW-1:0] req_op1,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [W-1:0]   resp_result,
    output logic           resp_carry,
    output logic           resp_zero,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_carry,
    input  logic           alu_zero,
    output logic           busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           last_id_q, last_id_d;
    logic           cur_id_q, cur_id_d;
    logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [1:0]     resp_valid_q, resp_valid_d;
    logic [W-1:0]   resp_result_q, resp_result_d;
    logic           resp_carry_q, resp_carry_d;
    logic           resp_zero_q, resp_zero_d;
    logic           grant;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        if (req_valid == 2'b11) grant = ~last_id_q;
        else                    grant = req_valid[1];
    end

    assign req_ready = (state_q == IDLE) ? (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;

    always_comb begin
        state_d       = state_q;
        last_id_d     = last_id_q;
        cur_id_d      = cur_id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_carry_d  = resp_carry_q;
        resp_zero_d   = resp_zero_q;
        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    alu_a_d   = grant ? req_a1  : req_a0;
                    alu_b_d   = grant ? req_b1  : req_b0;
                    alu_op_d  = grant ? req_op1 : req_op0;
                    cur_id_d  = grant;
                    last_id_d = grant;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = alu_result;
                resp_carry_d  = alu_carry;
                resp_zero_d   = alu_zero;
                resp_valid_d  = cur_id_q ? 2'b10 : 2'b01;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready[cur_id_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = 2'b00;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_id_q     <= 1'b1;
            cur_id_q      <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            resp_valid_q  <= 2'b00;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_id_q     <= last_id_d;
            cur_id_q      <= cur_id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_carry_q  <= resp_carry_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign resp_zero   = resp_zero_q;
    assign busy        = (state_q != IDLE);
endmodule
